// File: rtl/matrix_print_engine_pkg.sv
// Shared types and ASCII constants for the matrix print engine.
// Optional header line is enabled by defining PRINT_HEADER_EN.
package matrix_print_engine_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_DIM,
    ST_HDR_MH,
    ST_HDR_ML,
    ST_HDR_X,
    ST_HDR_NH,
    ST_HDR_NL,
    ST_FETCH,
    ST_WAIT,
    ST_CONVERT,
    ST_SIGN,
    ST_DIGIT,
    ST_SEP,
    ST_CR,
    ST_LF,
    ST_DONE
  } state_t;

  localparam logic [3:0] MODE_P1 = 4'd1;
  localparam logic [3:0] MODE_P2 = 4'd2;
  localparam logic [3:0] MODE_P3 = 4'd3;
  localparam logic [3:0] MODE_P5 = 4'd5;

  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0d;
  localparam logic [7:0] ASC_LF    = 8'h0a;
  localparam logic [7:0] ASC_MINUS = 8'h2d;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_ONE   = 8'h31;
  localparam logic [7:0] ASC_X     = 8'h78;

  function automatic logic is_print_mode(
    input logic [3:0] m
  );
    return (m == MODE_P1) || (m == MODE_P2) ||
           (m == MODE_P3) || (m == MODE_P5);
  endfunction

  function automatic logic [7:0] ascii_digit(
    input logic [3:0] d
  );
    return ASC_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/dec_digit_serializer.sv
// Iterative divide-by-10: emits decimal digits of an unsigned value,
// least significant first, one digit per DATA_W+1 cycles.
module dec_digit_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              digit_valid,
  output logic [3:0]        digit,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_W);

  logic [DATA_W-1:0] quo;
  logic [3:0]        rem;
  logic [CNT_W-1:0]  cnt;
  logic              busy_q;
  logic [4:0]        rem_sh;
  logic [4:0]        rem_sub;
  logic              ge;

  always_comb begin
    rem_sh  = {rem, quo[DATA_W-1]};
    ge      = rem_sh >= 5'd10;
    rem_sub = rem_sh - 5'd10;
  end

  assign busy        = busy_q;
  assign digit_valid = busy_q && (cnt == CNT_LAST);
  assign digit       = rem;
  assign done        = digit_valid && (quo == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo    <= '0;
      rem    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      quo    <= value;
      rem    <= '0;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt == CNT_LAST) begin
        // quotient becomes the next dividend
        if (quo == '0) begin
          busy_q <= 1'b0;
        end else begin
          rem <= '0;
          cnt <= '0;
        end
      end else begin
        quo <= {quo[DATA_W-2:0], ge};
        rem <= ge ? rem_sub[3:0] : rem_sh[3:0];
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_print_engine.sv
// Walks a matrix over read port A and streams it as ASCII text.
// Define PRINT_HEADER_EN to prefix the stream with "<m>x<n>\r\n".
module matrix_print_engine
  import matrix_print_engine_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 7,
  parameter int DIM_W      = 4,
  parameter int MAX_DIGITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              print_req,
  input  logic [3:0]        print_mode,
  input  logic [ID_W-1:0]   print_target_id,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ID_W-1:0]   printer_id,
  output logic [DIM_W-1:0]  printer_row,
  output logic [DIM_W-1:0]  printer_col,
  output logic              printer_active,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              print_done
);

  localparam int IDX_W = $clog2(MAX_DIGITS + 1);

  state_t             state, state_nx;
  logic [3:0]         mode_q;
  logic [DIM_W-1:0]   m_q, n_q;
  logic               neg_q;
  logic               nl_only;
  logic               hdr_line;
  logic [IDX_W-1:0]   ndig;
  logic [3:0]         dig_buf [MAX_DIGITS];

  logic               go_nl;
  logic               row_end;
  logic               last;
  logic               xfer;
  logic [DATA_W-1:0]  mag;
  logic               ser_start;
  logic               ser_busy;
  logic               ser_dv;
  logic [3:0]         ser_dig;
  logic               ser_done;

  assign go_nl = !is_print_mode(mode_q) ||
                 (dim_m == '0) || (dim_n == '0);
  assign row_end = printer_col == n_q - DIM_W'(1);
  assign last = row_end &&
                (printer_row == m_q - DIM_W'(1));
  assign xfer = tx_valid && tx_ready;
  assign mag = mem_data[DATA_W-1] ?
               (~mem_data + DATA_W'(1)) : mem_data;
  assign printer_active = state != ST_IDLE;
  assign print_done = state == ST_DONE;

`ifdef PRINT_HEADER_EN
  function automatic logic [3:0] dec_lo(
    input logic [DIM_W-1:0] v
  );
    return 4'(v >= DIM_W'(10) ? v - DIM_W'(10) : v);
  endfunction
`endif

  dec_digit_serializer #(
    .DATA_W(DATA_W)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (ser_start),
    .value      (mag),
    .busy       (ser_busy),
    .digit_valid(ser_dv),
    .digit      (ser_dig),
    .done       (ser_done)
  );

  always_comb begin
    state_nx  = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    ser_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (print_req) state_nx = ST_LOAD_DIM;
      end
      ST_LOAD_DIM: begin
        if (go_nl) begin
          state_nx = ST_CR;
        end else begin
`ifdef PRINT_HEADER_EN
          state_nx = (dim_m >= DIM_W'(10)) ?
                     ST_HDR_MH : ST_HDR_ML;
`else
          state_nx = ST_FETCH;
`endif
        end
      end
`ifdef PRINT_HEADER_EN
      ST_HDR_MH: begin
        tx_valid = 1'b1;
        tx_data  = ASC_ONE;
        if (tx_ready) state_nx = ST_HDR_ML;
      end
      ST_HDR_ML: begin
        tx_valid = 1'b1;
        tx_data  = ascii_digit(dec_lo(m_q));
        if (tx_ready) state_nx = ST_HDR_X;
      end
      ST_HDR_X: begin
        tx_valid = 1'b1;
        tx_data  = ASC_X;
        if (tx_ready)
          state_nx = (n_q >= DIM_W'(10)) ?
                     ST_HDR_NH : ST_HDR_NL;
      end
      ST_HDR_NH: begin
        tx_valid = 1'b1;
        tx_data  = ASC_ONE;
        if (tx_ready) state_nx = ST_HDR_NL;
      end
      ST_HDR_NL: begin
        tx_valid = 1'b1;
        tx_data  = ascii_digit(dec_lo(n_q));
        if (tx_ready) state_nx = ST_CR;
      end
`endif
      ST_FETCH: state_nx = ST_WAIT;
      ST_WAIT: begin
        ser_start = !ser_busy;
        if (!ser_busy) state_nx = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (ser_done)
          state_nx = neg_q ? ST_SIGN : ST_DIGIT;
      end
      ST_SIGN: begin
        tx_valid = 1'b1;
        tx_data  = ASC_MINUS;
        if (tx_ready) state_nx = ST_DIGIT;
      end
      ST_DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = ascii_digit(
                     dig_buf[ndig - IDX_W'(1)]);
        if (tx_ready && ndig == IDX_W'(1))
          state_nx = row_end ? ST_CR : ST_SEP;
      end
      ST_SEP: begin
        tx_valid = 1'b1;
        tx_data  = ASC_SP;
        if (tx_ready) state_nx = ST_FETCH;
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = ASC_CR;
        if (tx_ready) state_nx = ST_LF;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = ASC_LF;
        if (tx_ready) begin
          if (hdr_line)
            state_nx = ST_FETCH;
          else if (nl_only || last)
            state_nx = ST_DONE;
          else
            state_nx = ST_FETCH;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      printer_id  <= '0;
      printer_row <= '0;
      printer_col <= '0;
      mode_q      <= '0;
      m_q         <= '0;
      n_q         <= '0;
      neg_q       <= 1'b0;
      nl_only     <= 1'b0;
      hdr_line    <= 1'b0;
      ndig        <= '0;
      for (int i = 0; i < MAX_DIGITS; i++)
        dig_buf[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && print_req) begin
        printer_id <= print_target_id;
        mode_q     <= print_mode;
      end
      if (state == ST_LOAD_DIM) begin
        m_q     <= dim_m;
        n_q     <= dim_n;
        nl_only <= go_nl;
`ifdef PRINT_HEADER_EN
        hdr_line <= !go_nl;
`else
        hdr_line <= 1'b0;
`endif
      end
      if (ser_start) neg_q <= mem_data[DATA_W-1];
      if (ser_dv && ndig < IDX_W'(MAX_DIGITS)) begin
        dig_buf[ndig] <= ser_dig;
        ndig          <= ndig + IDX_W'(1);
      end
      if (state == ST_DIGIT && xfer)
        ndig <= ndig - IDX_W'(1);
      if (state == ST_SEP && xfer)
        printer_col <= printer_col + DIM_W'(1);
      if (state == ST_LF && xfer) begin
        // row-major wrap; the final element returns to (0,0)
        if (hdr_line) begin
          hdr_line <= 1'b0;
        end else if (!nl_only) begin
          printer_col <= '0;
          printer_row <= last ? '0 :
                         printer_row + DIM_W'(1);
        end
      end
    end
  end

endmodule
